block_1024: RTL and testbench

- Self-contained compressive-sensing front end for a 256x256 8-bit test image.
- Walks the image as 1024 non-overlapping 8x8 blocks in raster order. Pixel values come from an internal synthetic image function.
- For each block, computes 48 signed Walsh-Hadamard measurements and streams them out.
- Asserts finish_flag once all blocks are done. Sits ahead of the frequency-domain inverse reconstruction stage, which consumes 48 x 16-bit measurements per block.

---
 rtl/block_1024.sv | 115 +++++++++++
 tb/tb_block_1024.sv | 138 +++++++++++++
 2 files changed

// File: rtl/block_1024.sv
// Compressive-sensing front end: walks a synthetic 256x256 image as 8x8 blocks and
// streams NUM_MEAS signed Walsh-Hadamard measurements per block.
module block_1024 #(
  parameter int NUM_BLOCKS = 1024,
  parameter int NUM_MEAS   = 48,
  parameter int MEAS_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     finish_flag,
  output logic [9:0]               block_idx,
  output logic                     meas_valid,
  output logic [5:0]               meas_index,
  output logic signed [MEAS_W-1:0] meas_data
);

  typedef enum logic [1:0] {LOAD, STREAM, DONE} state_t;

  state_t                   state, state_nxt;
  logic [5:0]               cnt;
  logic signed [MEAS_W-1:0] acc [NUM_MEAS];

  logic [7:0]               pix_x, pix_y, pixel;
  logic signed [MEAS_W-1:0] pix_s;
  logic                     load_last, stream_last, last_block;

  logic                     valid_nxt, finish_nxt;
  logic signed [MEAS_W-1:0] data_sel;

  // Odd parity of (k AND i) selects the -1 Hadamard entry.
  function automatic logic hadamard_neg(input logic [5:0] k, input logic [5:0] i);
    return ^(k & i);
  endfunction

  function automatic logic signed [MEAS_W-1:0] signed_term(
    input logic neg, input logic signed [MEAS_W-1:0] pix);
    return neg ? -pix : pix;
  endfunction

  // Block b occupies rows 8*b[9:5].. and columns 8*b[4:0]..; i splits into row/col.
  assign pix_y = {block_idx[9:5], cnt[5:3]};
  assign pix_x = {block_idx[4:0], cnt[2:0]};
  assign pixel = pix_x ^ pix_y;
  assign pix_s = $signed({{(MEAS_W-8){1'b0}}, pixel});

  assign load_last   = (state == LOAD) && (cnt == 6'd63);
  assign stream_last = (state == STREAM) && (cnt == 6'(NUM_MEAS-1));
  assign last_block  = (block_idx == 10'(NUM_BLOCKS-1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LOAD;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (load_last) state_nxt = STREAM;
      STREAM:  if (stream_last) state_nxt = last_block ? DONE : LOAD;
      DONE:    state_nxt = DONE;
      default: state_nxt = LOAD;
    endcase
  end

  always_comb begin
    valid_nxt  = (state == STREAM);
    finish_nxt = (state == DONE);
    data_sel   = '0;
    for (int k = 0; k < NUM_MEAS; k++)
      if (cnt == 6'(k)) data_sel = acc[k];
  end

  // One counter serves as pixel index in LOAD and measurement index in STREAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      block_idx <= '0;
    end else begin
      case (state)
        LOAD:    cnt <= cnt + 6'd1;
        STREAM:  cnt <= stream_last ? 6'd0 : cnt + 6'd1;
        default: cnt <= cnt;
      endcase
      if (stream_last && !last_block) block_idx <= block_idx + 10'd1;
    end
  end

  // Accumulate stage: every row of the Hadamard matrix updates in parallel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_MEAS; k++) acc[k] <= '0;
    end else if (state == LOAD) begin
      for (int k = 0; k < NUM_MEAS; k++)
        acc[k] <= ((cnt == 6'd0) ? '0 : acc[k]) + signed_term(hadamard_neg(6'(k), cnt), pix_s);
    end
  end

  // Output register stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meas_valid  <= 1'b0;
      meas_index  <= '0;
      meas_data   <= '0;
      finish_flag <= 1'b0;
    end else begin
      meas_valid  <= valid_nxt;
      finish_flag <= finish_nxt;
      if (valid_nxt) begin
        meas_index <= cnt;
        meas_data  <= data_sel;
      end
    end
  end

endmodule

// File: tb/tb_block_1024.sv
// Directed bench for block_1024 using a reduced block count so full runs stay short.
module tb_block_1024;

  localparam int NB  = 40;
  localparam int BLK = 112;

  logic               clk;
  logic               reset;
  logic               finish_flag;
  logic [9:0]         block_idx;
  logic               meas_valid;
  logic [5:0]         meas_index;
  logic signed [15:0] meas_data;

  int n_checks = 0;
  int n_errors = 0;

  block_1024 #(.NUM_BLOCKS(NB), .NUM_MEAS(48), .MEAS_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .finish_flag (finish_flag),
    .block_idx   (block_idx),
    .meas_valid  (meas_valid),
    .meas_index  (meas_index),
    .meas_data   (meas_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int model(input int b, input int k);
    int sum = 0;
    for (int i = 0; i < 64; i++) begin
      int y = 8 * (b >> 5) + (i >> 3);
      int x = 8 * (b & 31) + (i & 7);
      int p = (x ^ y) & 255;
      if ($countones(k & i) % 2 == 1) sum -= p;
      else                            sum += p;
    end
    return sum;
  endfunction

  // Sample each cycle n (counted from reset release) 1 time unit after its edge.
  task automatic run(input int ncyc, input bit full);
    int bad_t = 0, bad_f = 0, bad_i = 0, bad_d = 0, bad_b = 0, pulses = 0;
    for (int n = 0; n < ncyc; n++) begin
      int  b, ph;
      bit  in_run, exp_v;
      @(posedge clk); #1;
      b      = n / BLK;
      ph     = n % BLK;
      in_run = (n < NB * BLK);
      exp_v  = in_run && (ph >= 64);
      if (meas_valid !== exp_v) bad_t++;
      if (finish_flag !== !in_run) bad_f++;
      if (meas_valid === 1'b1) pulses++;
      if (meas_valid === 1'b1 && exp_v) begin
        if (int'(meas_index) != ph - 64) bad_i++;
        if (int'(meas_data) != model(b, ph - 64)) bad_d++;
      end
      if (in_run && ph == 64 && int'(block_idx) != b) bad_b++;
      if (!in_run && int'(block_idx) != NB - 1) bad_b++;
      if (n == 63) check("valid_c63", int'(meas_valid), 0);
      if (n == 64) begin
        check("valid_c64", int'(meas_valid), 1);
        check("b0_k0_data", int'(meas_data), 224);
        check("b0_k0_index", int'(meas_index), 0);
        check("b0_block_idx", int'(block_idx), 0);
      end
      if (n == 65) check("b0_k1_data", int'(meas_data), 0);
      if (n == BLK + 64) check("b1_k0_data", int'(meas_data), 736);
      if (n == 32 * BLK + 64) check("b32_k0_data", int'(meas_data), 736);
      if (n == 33 * BLK + 64) check("b33_k0_data", int'(meas_data), 224);
      if (n == NB * BLK - 1) check("finish_before", int'(finish_flag), 0);
      if (n == NB * BLK) check("finish_rise", int'(finish_flag), 1);
    end
    check("valid_timing_errs", bad_t, 0);
    check("finish_errs", bad_f, 0);
    check("index_errs", bad_i, 0);
    check("data_errs", bad_d, 0);
    check("block_idx_errs", bad_b, 0);
    if (full) check("pulse_count", pulses, NB * 48);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_finish", int'(finish_flag), 0);
    check("rst_valid", int'(meas_valid), 0);
    check("rst_block", int'(block_idx), 0);
    check("rst_data", int'(meas_data), 0);
    check("rst_index", int'(meas_index), 0);
    @(negedge clk);
    reset = 1'b0;

    // Partial run up to block 5, k=20, then reset asynchronously mid-stream.
    run(5 * BLK + 64 + 21, 1'b0);
    check("mid_valid", int'(meas_valid), 1);
    check("mid_index", int'(meas_index), 20);
    check("mid_block", int'(block_idx), 5);
    #2 reset = 1'b1;
    #1;
    check("async_valid", int'(meas_valid), 0);
    check("async_index", int'(meas_index), 0);
    check("async_data", int'(meas_data), 0);
    check("async_block", int'(block_idx), 0);
    check("async_finish", int'(finish_flag), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run(NB * BLK + 1005, 1'b1);
    check("done_finish", int'(finish_flag), 1);
    check("done_valid", int'(meas_valid), 0);

    // Reset while in DONE; finish_flag must drop before the next edge.
    #2 reset = 1'b1;
    #1;
    check("done_rst_finish", int'(finish_flag), 0);
    check("done_rst_block", int'(block_idx), 0);
    @(negedge clk);
    reset = 1'b0;

    run(NB * BLK + 1005, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
